// File: rtl/ram_line_reader.sv
// Burst reader: streams RAM lines through a 4-deep FIFO with read credit.
// Define RAM_LINE_READER_STATS_EN to enable the stalled-cycle counter.
module ram_line_reader #(
  parameter int NUMBER_OF_LINES = 16,
  parameter int DATA_WIDTH      = 128,
  localparam int AW = $clog2(NUMBER_OF_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW:0]           num_lines,
  output logic                  r_en,
  output logic [AW-1:0]         addr_r,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam logic [AW-1:0] LAST   = AW'(NUMBER_OF_LINES - 1);
  localparam logic [AW:0]   LN_ONE = (AW+1)'(1);

  state_t                state;
  logic [AW:0]           rd_left;
  logic [AW:0]           pop_left;
  logic [2:0]            count;
  logic [2:0]            count_nx;
  logic [2:0]            inflight;
  logic [2:0]            inflight_nx;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [DATA_WIDTH-1:0] fifo [4];
  logic                  push;
  logic                  pop;
  logic                  dec;
  logic                  can_read;
  logic [AW-1:0]         next_addr;

  // Returns that land while idle belong to a discarded burst.
  assign push      = mem_valid && (state != IDLE);
  assign dec       = push && (inflight != 3'd0);
  assign out_valid = (count != 3'd0);
  assign out_data  = fifo[rd_ptr];
  assign pop       = out_valid && out_ready;

  assign count_nx    = count + 3'(push) - 3'(pop);
  assign inflight_nx = inflight + 3'(r_en) - 3'(dec);
  assign can_read    = ({1'b0, count_nx} + {1'b0, inflight_nx}) < 4'd4;
  assign next_addr   = !r_en ? addr_r :
                       (addr_r == LAST) ? '0 : addr_r + AW'(1);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_en     <= 1'b0;
      addr_r   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_left  <= '0;
      pop_left <= '0;
      count    <= '0;
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      done     <= 1'b0;
      count    <= count_nx;
      inflight <= inflight_nx;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        pop_left <= pop_left - LN_ONE;
      end
      unique case (state)
        IDLE: begin
          r_en <= 1'b0;
          if (start) begin
            if (num_lines == '0) begin
              done <= 1'b1;
            end else begin
              state    <= READ;
              busy     <= 1'b1;
              r_en     <= 1'b1;
              addr_r   <= start_addr;
              rd_left  <= num_lines - LN_ONE;
              pop_left <= num_lines;
            end
          end
        end
        READ: begin
          addr_r <= next_addr;
          if (rd_left == '0) begin
            r_en  <= 1'b0;
            state <= DRAIN;
          end else if (can_read) begin
            r_en    <= 1'b1;
            rd_left <= rd_left - LN_ONE;
          end else begin
            r_en <= 1'b0;
          end
        end
        DRAIN: begin
          r_en   <= 1'b0;
          addr_r <= next_addr;
          if (pop && pop_left == LN_ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_LINE_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_line_reader.sv
// Directed bench for ram_line_reader with a queue-based data scoreboard.
module tb_ram_line_reader;

  localparam int NL = 16;
  localparam int DW = 128;
  localparam int AW = $clog2(NL);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_lines;
  logic          r_en;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] rd_data;
  logic          mem_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] ram [NL];
  logic [DW-1:0] exp_q [$];
  int            errors;
  int            checks;
  int            ren_cnt;
  int            ren0;

  ram_line_reader #(
    .NUMBER_OF_LINES(NL),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .num_lines (num_lines),
    .r_en      (r_en),
    .addr_r    (addr_r),
    .rd_data   (rd_data),
    .mem_valid (mem_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency RAM, deliberately not tied to rst_n.
  always @(posedge clk) begin
    mem_valid <= r_en;
    rd_data   <= ram[addr_r];
  end

  always @(negedge clk) begin
    if (r_en) ren_cnt++;
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected nothing", out_data);
      end else begin
        chk("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lines(input int a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ram[(a + i) % NL]);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, DW'(seen), DW'(1));
    tick();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    ren_cnt    = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    num_lines  = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < NL; i++) ram[i] = {4{32'hC0DE_0000 + 32'(i)}};
    repeat (3) tick();

    @(negedge clk);
    chk("rst_r_en", DW'(r_en), DW'(0));
    chk("rst_addr", DW'(addr_r), DW'(0));
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_stall", DW'(stall_cnt), DW'(0));
    rst_n = 1'b1;
    tick();

    // Basic burst: exact cycle-by-cycle timing.
    start_addr = 4'd2;
    num_lines  = 5'd5;
    start      = 1'b1;
    expect_lines(2, 5);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("b1_r_en_c%0d", k), DW'(r_en), DW'(k <= 5));
      if (k <= 5) chk($sformatf("b1_addr_c%0d", k), DW'(addr_r), DW'(1 + k));
      chk($sformatf("b1_valid_c%0d", k), DW'(out_valid), DW'(k >= 3 && k <= 7));
      chk($sformatf("b1_done_c%0d", k), DW'(done), DW'(k == 8));
      chk($sformatf("b1_busy_c%0d", k), DW'(busy), DW'(k <= 7));
      tick();
    end

    // Address wrap at the top of the RAM.
    start_addr = 4'd14;
    num_lines  = 5'd4;
    start      = 1'b1;
    expect_lines(14, 4);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_r_en_c%0d", k), DW'(r_en), DW'(1));
      chk($sformatf("wrap_addr_c%0d", k), DW'(addr_r), DW'((13 + k) % NL));
      tick();
    end
    wait_done("wrap_done");

    // Zero-length burst, then a start accepted while done is high.
    ren0       = ren_cnt;
    start_addr = 4'd7;
    num_lines  = 5'd0;
    start      = 1'b1;
    tick();
    @(negedge clk);
    chk("zero_done", DW'(done), DW'(1));
    chk("zero_busy", DW'(busy), DW'(0));
    chk("zero_r_en", DW'(r_en), DW'(0));
    start_addr = 4'd5;
    num_lines  = 5'd2;
    expect_lines(5, 2);
    tick();
    start = 1'b0;
    chk("zero_no_reads", DW'(ren_cnt - ren0), DW'(0));
    @(negedge clk);
    chk("b2b_busy", DW'(busy), DW'(1));
    chk("b2b_r_en", DW'(r_en), DW'(1));
    chk("b2b_addr", DW'(addr_r), DW'(5));
    wait_done("b2b_done");

    // Back-pressure: ten stalled cycles with a full FIFO.
    ren0       = ren_cnt;
    out_ready  = 1'b0;
    start_addr = 4'd8;
    num_lines  = 5'd6;
    start      = 1'b1;
    expect_lines(8, 6);
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("stall_valid", DW'(out_valid), DW'(1));
    repeat (10) @(posedge clk);
    chk("stall_reads", DW'(ren_cnt - ren0), DW'(4));
    #1;
    out_ready = 1'b1;
    wait_done("stall_done");
    chk("stall_total_reads", DW'(ren_cnt - ren0), DW'(6));
`ifdef RAM_LINE_READER_STATS_EN
    chk("stall_cnt", DW'(stall_cnt), DW'(10));
`else
    chk("stall_cnt", DW'(stall_cnt), DW'(0));
`endif

    // Start pulsed mid-burst must be ignored.
    ren0       = ren_cnt;
    start_addr = 4'd4;
    num_lines  = 5'd5;
    start      = 1'b1;
    expect_lines(4, 5);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("ign_r_en_c%0d", k), DW'(r_en), DW'(k <= 5));
      if (k <= 5) chk($sformatf("ign_addr_c%0d", k), DW'(addr_r), DW'(3 + k));
      if (k == 2) begin
        start_addr = 4'd9;
        num_lines  = 5'd2;
        start      = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    wait_done("ign_done");
    repeat (3) tick();
    chk("ign_reads", DW'(ren_cnt - ren0), DW'(5));
    chk("ign_idle_busy", DW'(busy), DW'(0));

    // Reset mid-burst while a RAM return is still in flight.
    start_addr = 4'd3;
    num_lines  = 5'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_r_en", DW'(r_en), DW'(0));
    chk("mid_rst_addr", DW'(addr_r), DW'(0));
    chk("mid_rst_valid", DW'(out_valid), DW'(0));
    chk("mid_rst_busy", DW'(busy), DW'(0));
    chk("mid_rst_done", DW'(done), DW'(0));
    chk("mid_rst_stall", DW'(stall_cnt), DW'(0));
    chk("mid_rst_memv", DW'(mem_valid), DW'(1));
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stray_valid", DW'(out_valid), DW'(0));
    chk("stray_busy", DW'(busy), DW'(0));
    tick();

    start_addr = 4'd0;
    num_lines  = 5'd3;
    start      = 1'b1;
    expect_lines(0, 3);
    tick();
    start = 1'b0;
    wait_done("post_rst_done");
    repeat (2) tick();
    chk("sb_empty", DW'(exp_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
